regfile_wb_ctrl: RTL



---
 rtl/tp_rf_pkg.sv | 11 +
 rtl/rr_arb2.sv | 46 ++++
 rtl/regfile_wb_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/tp_rf_pkg.sv
// Shared register-file parameters and the write-port controller state type.
package tp_rf_pkg;
    localparam int NREGS = 16;
    localparam int AW    = 5;
    localparam int DW    = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, zero latency.
// A grant is only issued while en_i is high, and the pointer then moves to the loser.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vld0_i,
    input  logic       vld1_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);
    import tp_rf_pkg::*;

    // 0 favours requester 0 on a tie, 1 favours requester 1
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (vld0_i && vld1_i) begin
                gnt_o = ptr_q ? 2'b10 : 2'b01;
            end else if (vld0_i) begin
                gnt_o = 2'b01;
            end else if (vld1_i) begin
                gnt_o = 2'b10;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_o[0]) begin
            ptr_d = 1'b1;
        end else if (gnt_o[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write port controller: zero-clear sweep, then round-robin write-back.
// Grant to strobe is one cycle; readies stay low during the sweep and on a clear request.
module regfile_wb_ctrl #(
    parameter int NREGS = tp_rf_pkg::NREGS,
    parameter int AW    = tp_rf_pkg::AW,
    parameter int DW    = tp_rf_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    input  logic          clr_req,
    output logic [AW-1:0] rf_addr_c,
    output logic [DW-1:0] rf_din_c,
    output logic          rf_wrback,
    output logic          busy,
    output logic          err_addr
);
    import tp_rf_pkg::*;

    localparam logic [AW:0] NREGS_V = (AW+1)'(NREGS);

    state_e        state_q;
    logic [AW:0]   cnt_q;
    logic [AW-1:0] rf_addr_c_q;
    logic [DW-1:0] rf_din_c_q;
    logic          rf_wrback_q;
    logic          err_addr_q;

    logic [1:0]    gnt;
    logic          arb_en;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic          addr_ok;

    assign arb_en = (state_q == RUN) && !clr_req;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .vld0_i (req0_valid),
        .vld1_i (req1_valid),
        .en_i   (arb_en),
        .gnt_o  (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign sel_addr   = gnt[1] ? req1_addr : req0_addr;
    assign sel_data   = gnt[1] ? req1_data : req0_data;
    assign addr_ok    = {1'b0, sel_addr} < NREGS_V;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR;
            cnt_q       <= '0;
            rf_addr_c_q <= '0;
            rf_din_c_q  <= '0;
            rf_wrback_q <= 1'b0;
            err_addr_q  <= 1'b0;
        end else begin
            rf_wrback_q <= 1'b0;
            err_addr_q  <= 1'b0;
            case (state_q)
                CLEAR: begin
                    // cnt == NREGS is the settle cycle in which the last zero strobe is visible
                    if (cnt_q == NREGS_V) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end else begin
                        rf_wrback_q <= 1'b1;
                        rf_addr_c_q <= cnt_q[AW-1:0];
                        rf_din_c_q  <= '0;
                        cnt_q       <= cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (clr_req) begin
                        // address 0 is issued on entry so the first zero strobe follows the request directly
                        state_q     <= CLEAR;
                        rf_wrback_q <= 1'b1;
                        rf_addr_c_q <= '0;
                        rf_din_c_q  <= '0;
                        cnt_q       <= (AW+1)'(1);
                    end else if (gnt != 2'b00) begin
                        if (addr_ok) begin
                            rf_wrback_q <= 1'b1;
                            rf_addr_c_q <= sel_addr;
                            rf_din_c_q  <= sel_data;
                        end else begin
                            err_addr_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    assign rf_addr_c = rf_addr_c_q;
    assign rf_din_c  = rf_din_c_q;
    assign rf_wrback = rf_wrback_q;
    assign err_addr  = err_addr_q;
    assign busy      = (state_q == CLEAR);
endmodule
